// File: rtl/rs_gf_pkg.sv
// GF(2^M) helpers shared by the Forney engine: default field constants,
// elaboration-time log/antilog generators, log-domain arithmetic, FSM states.
package rs_gf_pkg;

  localparam int unsigned GF_M        = 8;
  localparam int unsigned GF_NQ       = (1 << GF_M) - 1;
  localparam int unsigned GF_LOG_ZERO = GF_NQ;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } fsm_state_e;

  // alpha^e in polynomial basis for field GF(2^m) generated by prim
  function automatic int unsigned gf_antilog_fn(int unsigned m, int unsigned prim,
                                                int unsigned e);
    int unsigned x;
    x = 1;
    for (int unsigned i = 0; i < e; i++) begin
      x = x << 1;
      if ((x >> m) != 0) x = x ^ prim;
    end
    return x;
  endfunction

  // discrete log of v; field zero maps to the all-ones LOG_ZERO code
  function automatic int unsigned gf_log_fn(int unsigned m, int unsigned prim,
                                            int unsigned v);
    int unsigned nq;
    int unsigned x;
    int unsigned res;
    nq  = (1 << m) - 1;
    res = nq;
    x   = 1;
    for (int unsigned i = 0; i < nq; i++) begin
      if (x == v && v != 0) res = i;
      x = x << 1;
      if ((x >> m) != 0) x = x ^ prim;
    end
    return res;
  endfunction

  // log-domain multiply; LOG_ZERO (== nq) is absorbing
  function automatic int unsigned gf_mul_log(int unsigned a, int unsigned b,
                                             int unsigned nq);
    if (a == nq || b == nq) return nq;
    return (a + b) % nq;
  endfunction

  // log-domain inverse of a non-zero element
  function automatic int unsigned gf_inv_log(int unsigned a, int unsigned nq);
    if (a == nq) return nq;
    return (nq - a) % nq;
  endfunction

  // exponent subtraction a - b mod nq (b <= nq)
  function automatic int unsigned gf_sub_log(int unsigned a, int unsigned b,
                                             int unsigned nq);
    return (a + nq - b) % nq;
  endfunction

endpackage

// File: rtl/rs_gf_lut.sv
// Combinational GF(2^M) log/antilog ROM with independent read ports on each
// table. Contents are generated at elaboration from PRIM_POLY.
module rs_gf_lut
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M,
  parameter int unsigned PRIM_POLY = 'h11D,
  parameter int unsigned NA        = 3,
  parameter int unsigned NL        = 2
) (
  input  logic [NA-1:0][M-1:0] alog_idx,
  output logic [NA-1:0][M-1:0] alog_val,
  input  logic [NL-1:0][M-1:0] log_vec,
  output logic [NL-1:0][M-1:0] log_val
);

  localparam int unsigned SZ = 1 << M;
  localparam int unsigned NQ = SZ - 1;

  logic [M-1:0] alog_tab [SZ];
  logic [M-1:0] log_tab  [SZ];

  // constant tables; antilog of LOG_ZERO is field zero
  for (genvar i = 0; i < SZ; i++) begin : g_tab
    localparam int unsigned AV = (int'(i) == int'(NQ)) ? 0 : gf_antilog_fn(M, PRIM_POLY, i);
    localparam int unsigned LV = gf_log_fn(M, PRIM_POLY, i);
    assign alog_tab[i] = M'(AV);
    assign log_tab[i]  = M'(LV);
  end

  // antilog reads
  always_comb begin
    alog_val = '0;
    for (int p = 0; p < int'(NA); p++) alog_val[p] = alog_tab[alog_idx[p]];
  end

  // log reads
  always_comb begin
    log_val = '0;
    for (int p = 0; p < int'(NL); p++) log_val[p] = log_tab[log_vec[p]];
  end

endmodule

// File: rtl/rs_forney_magnitude_seq.sv
// Sequential Forney error-magnitude engine: one location per T+1 cycles
// (T Horner/product steps, one divide). Optional degenerate-denominator
// flag enabled by defining RS_FORNEY_DEGEN_DETECT_EN.
module rs_forney_magnitude_seq
  import rs_gf_pkg::*;
#(
  parameter int unsigned M         = GF_M,
  parameter int unsigned T         = 8,
  parameter int unsigned PRIM_POLY = 'h11D,
  parameter int unsigned FCR       = 0
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     start,
  input  logic [$clog2(T+1)-1:0]   num_err,
  input  logic [T*M-1:0]           el_log,
  input  logic [T*M-1:0]           omega_log,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [T*M-1:0]           em
);

  localparam int unsigned NW    = $clog2(T + 1);
  localparam int unsigned IW    = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned NQ    = (1 << M) - 1;
  localparam int unsigned FCR_R = FCR % NQ;
  localparam int unsigned NA    = 3;
  localparam int unsigned NL    = 2;
  localparam logic [M-1:0]  LZ     = '1;
  localparam logic [NW-1:0] T_NW   = NW'(T);
  localparam logic [NW-1:0] K_LAST = NW'(T - 1);

  fsm_state_e            state;
  logic [NW-1:0]         ne_q, j_q, k_q;
  logic [T-1:0][M-1:0]   el_q, om_q, em_q;
  logic [M-1:0]          acc_log, den_log;

  logic [NA-1:0][M-1:0]  alog_idx, alog_val;
  logic [NL-1:0][M-1:0]  log_vec, log_val;
  logic [M-1:0]          ej, ek, xinv, div_exp, acc_next, den_next, em_val;
  logic [IW-1:0]         om_idx;
  logic                  calc_den;
  int unsigned           fcr_e;

  rs_gf_lut #(.M(M), .PRIM_POLY(PRIM_POLY), .NA(NA), .NL(NL)) u_lut (
    .alog_idx (alog_idx),
    .alog_val (alog_val),
    .log_vec  (log_vec),
    .log_val  (log_val)
  );

  // operand selection: Horner term, Omega coefficient, X_k*X_j^-1, divide exponent
  always_comb begin
    ej       = el_q[IW'(j_q)];
    ek       = el_q[IW'(k_q)];
    xinv     = M'(gf_inv_log(32'(ej), NQ));
    om_idx   = IW'(T - 1) - IW'(k_q);
    calc_den = (k_q != j_q) && (k_q < ne_q);
    fcr_e    = 32'((64'(FCR_R) * 64'(ej)) % 64'(NQ));
    div_exp  = M'(gf_sub_log(gf_sub_log(32'(acc_log), 32'(den_log), NQ), fcr_e, NQ));
    alog_idx = '0;
    alog_idx[0] = (state == S_DIV) ? div_exp : M'(gf_mul_log(32'(acc_log), 32'(xinv), NQ));
    alog_idx[1] = om_q[om_idx];
    alog_idx[2] = M'((32'(ek) + 32'(xinv)) % NQ);
  end

  // vector-domain additions fed back through the log table
  always_comb begin
    log_vec    = '0;
    log_vec[0] = alog_val[0] ^ alog_val[1];
    log_vec[1] = alog_val[2] ^ M'(1);
  end

  // next accumulator / denominator and the divided magnitude
  always_comb begin
    acc_next = log_val[0];
    den_next = calc_den ? M'(gf_mul_log(32'(den_log), 32'(log_val[1]), NQ)) : den_log;
    em_val   = (acc_log == LZ || den_log == LZ) ? '0 : alog_val[0];
  end

`ifdef RS_FORNEY_DEGEN_DETECT_EN
  logic fail_q;
  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  assign em = em_q;

  // control FSM and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      ne_q    <= '0;
      j_q     <= '0;
      k_q     <= '0;
      el_q    <= '0;
      om_q    <= '0;
      em_q    <= '0;
      acc_log <= LZ;
      den_log <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef RS_FORNEY_DEGEN_DETECT_EN
      fail_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ne_q <= (num_err > T_NW) ? T_NW : num_err;
            for (int i = 0; i < int'(T); i++)
              el_q[i] <= (el_log[i*M +: M] == LZ) ? '0 : el_log[i*M +: M];
            om_q    <= omega_log;
            em_q    <= '0;
            busy    <= 1'b1;
            j_q     <= '0;
            k_q     <= '0;
            acc_log <= LZ;
            den_log <= '0;
`ifdef RS_FORNEY_DEGEN_DETECT_EN
            fail_q  <= 1'b0;
`endif
            state   <= (num_err == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          acc_log <= acc_next;
          den_log <= den_next;
          if (k_q == K_LAST) state <= S_DIV;
          else               k_q   <= k_q + NW'(1);
        end
        S_DIV: begin
          em_q[IW'(j_q)] <= em_val;
`ifdef RS_FORNEY_DEGEN_DETECT_EN
          if (den_log == LZ) fail_q <= 1'b1;
`endif
          j_q     <= j_q + NW'(1);
          k_q     <= '0;
          acc_log <= LZ;
          den_log <= '0;
          state   <= (j_q + NW'(1) == ne_q) ? S_DONE : S_CALC;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_forney_magnitude_seq.sv
// Directed bench for rs_forney_magnitude_seq (T=8, M=8, 0x11D, FCR=0).
// Expected magnitudes come from constants and a polynomial-basis Forney model.
module tb_rs_forney_magnitude_seq;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        start;
  logic [3:0]  num_err;
  logic [63:0] el_log;
  logic [63:0] omega_log;
  logic        busy, done, fail;
  logic [63:0] em;

  int errors = 0;
  int checks = 0;

  rs_forney_magnitude_seq dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .start     (start),
    .num_err   (num_err),
    .el_log    (el_log),
    .omega_log (omega_log),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .em        (em)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] gpow(int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int v = 1; v < 256; v++) if (gmul(a, 8'(v)) == 8'h01) r = 8'(v);
    return r;
  endfunction

  // reference Forney: em_j = Omega(X_j^-1) / prod_{i!=j} (1 + X_i X_j^-1)
  function automatic logic [63:0] model_em(logic [3:0] ne_in, logic [63:0] el,
                                           logic [63:0] om);
    logic [63:0] r;
    logic [7:0]  xj, xi, s, xp, den, c;
    int ne;
    r  = '0;
    ne = (ne_in > 4'd8) ? 8 : int'(ne_in);
    for (int j = 0; j < ne; j++) begin
      xj = gpow(int'(el[j*8 +: 8]));
      xi = ginv(xj);
      s  = 8'h00;
      xp = 8'h01;
      for (int k = 0; k < 8; k++) begin
        c = om[k*8 +: 8];
        if (c != 8'hFF) s = s ^ gmul(gpow(int'(c)), xp);
        xp = gmul(xp, xi);
      end
      den = 8'h01;
      for (int i = 0; i < ne; i++)
        if (i != j) den = gmul(den, 8'h01 ^ gmul(gpow(int'(el[i*8 +: 8])), xi));
      r[j*8 +: 8] = (den == 8'h00) ? 8'h00 : gmul(s, ginv(den));
    end
    return r;
  endfunction

  // launch a job, scramble inputs after the accept edge, wait for done
  task automatic run_job(input logic [3:0] ne, input logic [63:0] el, input logic [63:0] om,
                         input int poke, output int lat, output logic bmid);
    @(negedge Clk);
    num_err = ne; el_log = el; omega_log = om; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; num_err = 4'hF;
    el_log = {$urandom, $urandom}; omega_log = {$urandom, $urandom};
    lat = -1; bmid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == poke) begin start = 1'b1; num_err = 4'd1; end
      @(posedge Clk); #1;
      start = 1'b0;
      if (c == 1) bmid = busy;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; start = 1'b0; num_err = '0; el_log = '0; omega_log = '0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", fail); end
    checks++; if (em !== 64'h0) begin errors++; $display("FAIL reset_em got=%h exp=0", em); end
    @(negedge Clk); Rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat; logic bm;
    run_job(4'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (lat !== 10) begin errors++; $display("FAIL single_latency got=%0d exp=10", lat); end
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got=%b exp=0", busy); end
    checks++; if (em[7:0] !== 8'h01) begin errors++; $display("FAIL single_em0 got=%h exp=01", em[7:0]); end
    checks++; if (em[63:8] !== 56'h0) begin errors++; $display("FAIL single_em_rest got=%h exp=0", em[63:8]); end
  endtask

  task automatic test_two();
    int lat; logic bm;
    run_job(4'd2, 64'h0100, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (lat !== 19) begin errors++; $display("FAIL two_latency got=%0d exp=19", lat); end
    checks++; if (em[7:0] !== 8'hF4) begin errors++; $display("FAIL two_em0 got=%h exp=f4", em[7:0]); end
    checks++; if (gmul(em[15:8], 8'h8F) !== 8'h01) begin errors++; $display("FAIL two_em1_inv got=%h exp_product=01", em[15:8]); end
    checks++; if (em[63:16] !== 48'h0) begin errors++; $display("FAIL two_em_rest got=%h exp=0", em[63:16]); end
  endtask

  task automatic test_zero();
    int lat; logic bm;
    run_job(4'd0, 64'h0302, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (em !== 64'h0) begin errors++; $display("FAIL zero_em got=%h exp=0", em); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic bm; logic [63:0] exp_em;
    exp_em = model_em(4'd3, 64'h05_0200, 64'hFFFF_FFFF_FFFF_0A03);
    run_job(4'd3, 64'h05_0200, 64'hFFFF_FFFF_FFFF_0A03, 3, lat, bm);
    checks++; if (lat !== 28) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=28", lat); end
    checks++; if (em !== exp_em) begin errors++; $display("FAIL busy_ignore_em got=%h exp=%h", em, exp_em); end
  endtask

  task automatic test_reset_abort();
    int lat; logic bm; logic [63:0] exp_em;
    @(negedge Clk);
    num_err = 4'd3; el_log = 64'h05_0200; omega_log = 64'hFFFF_FFFF_FFFF_0A03; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    repeat (5) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (em !== 64'h0) begin errors++; $display("FAIL abort_em got=%h exp=0", em); end
    @(negedge Clk); Rst_n = 1'b1;
    exp_em = model_em(4'd3, 64'h07_1403, 64'hFFFF_FFFF_FF22_0100);
    run_job(4'd3, 64'h07_1403, 64'hFFFF_FFFF_FF22_0100, 0, lat, bm);
    checks++; if (lat !== 28) begin errors++; $display("FAIL abort_rerun_latency got=%0d exp=28", lat); end
    checks++; if (em !== exp_em) begin errors++; $display("FAIL abort_rerun_em got=%h exp=%h", em, exp_em); end
  endtask

  task automatic test_clamp();
    int lat; logic bm; logic [63:0] exp_em;
    exp_em = model_em(4'd8, 64'h6E5A_3C21_1407_0300, 64'h11FF_2233_FF44_0500);
    run_job(4'd12, 64'h6E5A_3C21_1407_0300, 64'h11FF_2233_FF44_0500, 0, lat, bm);
    checks++; if (lat !== 73) begin errors++; $display("FAIL clamp_latency got=%0d exp=73", lat); end
    checks++; if (em !== exp_em) begin errors++; $display("FAIL clamp_em got=%h exp=%h", em, exp_em); end
  endtask

  task automatic test_exp255();
    int lat; logic bm;
    run_job(4'd2, 64'h01FF, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (em[7:0] !== 8'hF4) begin errors++; $display("FAIL exp255_em0 got=%h exp=f4", em[7:0]); end
    checks++; if (gmul(em[15:8], 8'h8F) !== 8'h01) begin errors++; $display("FAIL exp255_em1_inv got=%h exp_product=01", em[15:8]); end
  endtask

  task automatic test_degen();
    int lat; logic bm; logic exp_fail;
`ifdef RS_FORNEY_DEGEN_DETECT_EN
    exp_fail = 1'b1;
`else
    exp_fail = 1'b0;
`endif
    run_job(4'd2, 64'h0707, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (em[15:0] !== 16'h0) begin errors++; $display("FAIL degen_em got=%h exp=0000", em[15:0]); end
    checks++; if (fail !== exp_fail) begin errors++; $display("FAIL degen_fail got=%b exp=%b", fail, exp_fail); end
    run_job(4'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FF00, 0, lat, bm);
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL degen_clear got=%b exp=0", fail); end
    checks++; if (em[7:0] !== 8'h01) begin errors++; $display("FAIL degen_after_em0 got=%h exp=01", em[7:0]); end
  endtask

  task automatic test_random();
    int lat; logic bm; int ne; int e; logic [63:0] el, om, exp_em;
    logic [255:0] used;
    for (int it = 0; it < 6; it++) begin
      ne = $urandom_range(1, 8);
      used = '0; el = '0; om = '0;
      for (int s = 0; s < 8; s++) begin
        e = $urandom_range(0, 254);
        while (used[e]) e = (e + 1) % 255;
        used[e] = 1'b1;
        el[s*8 +: 8] = 8'(e);
        om[s*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      end
      exp_em = model_em(4'(ne), el, om);
      run_job(4'(ne), el, om, 0, lat, bm);
      checks++; if (lat !== ne * 9 + 1) begin errors++; $display("FAIL random_latency it=%0d got=%0d exp=%0d", it, lat, ne * 9 + 1); end
      checks++; if (em !== exp_em) begin errors++; $display("FAIL random_em it=%0d got=%h exp=%h", it, em, exp_em); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_zero();
    test_busy_ignore();
    test_reset_abort();
    test_clamp();
    test_exp255();
    test_degen();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
